// File: rtl/icache_refill_bridge_if.sv
// icache_refill_bridge_if
//   Bundles the ICache refill port and the AXI4 read channels (AR, R) that
//   the refill bridge sits between.
//   Modports:
//     slave  - the bridge. It answers ICache refill requests and masters the
//              AXI read channels.
//     master - the surroundings. This is the ICache requester together with
//              the AXI responder, as seen by a testbench or the parent.
//   Signals:
//     rd_req, rd_addr                  ICache request (into the bridge)
//     rd_rdy                           bridge ready for a request
//     ret_valid, ret_last,
//     ret_data, ret_err                line return to the ICache
//     arid, araddr, arlen, arsize,
//     arburst, arvalid, arready        AXI read address channel
//     rid, rdata, rresp, rlast,
//     rvalid, rready                   AXI read data channel
interface icache_refill_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int WORDS  = 4,
   parameter int ID_W   = 4
);
   logic                  rd_req;
   logic [ADDR_W-1:0]     rd_addr;
   logic                  rd_rdy;
   logic                  ret_valid;
   logic                  ret_last;
   logic [32*WORDS-1:0]   ret_data;
   logic                  ret_err;

   logic [ID_W-1:0]       arid;
   logic [ADDR_W-1:0]     araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   logic [ID_W-1:0]       rid;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport slave (
      input  rd_req, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
      output rd_rdy, ret_valid, ret_last, ret_data, ret_err,
             arid, araddr, arlen, arsize, arburst, arvalid, rready
   );

   modport master (
      output rd_req, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
      input  rd_rdy, ret_valid, ret_last, ret_data, ret_err,
             arid, araddr, arlen, arsize, arburst, arvalid, rready
   );
endinterface

// File: rtl/icache_refill_bridge.sv
// icache_refill_bridge
//   Turns each ICache line refill request into a single AXI4 INCR read burst
//   of WORDS 32-bit beats. The beats are collected into a line buffer, and the
//   whole line goes back to the ICache in a single ret_valid cycle. Only one
//   request is outstanding at a time.
//   Ports:
//     clk     clock
//     resetn  synchronous active-low reset (resets the AXI side as well)
//     bus     icache_refill_bridge_if.slave (ICache refill port + AXI AR/R)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | rd_rdy=1, waiting for rd_req; latches the line address
//   S_AR     | arvalid=1 until arready
//   S_RDATA  | rready=1, collecting beats with rid==ARID_VAL
//   S_RET    | one-cycle ret_valid/ret_last with the assembled line
module icache_refill_bridge #(
   parameter int              ADDR_W   = 32,
   parameter int              WORDS    = 4,
   parameter int              ID_W     = 4,
   parameter logic [ID_W-1:0] ARID_VAL = '0
) (
   input  logic                  clk,
   input  logic                  resetn,
   icache_refill_bridge_if.slave bus
);
   localparam int              CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_RDATA, S_RET} state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     araddr_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  err_q;
   logic [31:0]           words_q [WORDS];
   logic [32*WORDS-1:0]   line;
   logic [32*WORDS-1:0]   ret_hold_q;

   logic rdy, ar_vld, r_rdy, ret_vld;
   logic beat_ok, beat_last, unused_addr_bits;

   // Only the line address matters; the byte/word offset is dropped.
   assign unused_addr_bits = ^bus.rd_addr[3:0];

   assign beat_ok   = (state_q == S_RDATA) && bus.rvalid && (bus.rid == ARID_VAL);
   assign beat_last = (cnt_q == CNT_LAST);

   always_comb begin
      line = '0;
      for (int i = 0; i < WORDS; i++) line[32*i +: 32] = words_q[i];
   end

   always_comb begin
      state_d = state_q;
      rdy     = 1'b0;
      ar_vld  = 1'b0;
      r_rdy   = 1'b0;
      ret_vld = 1'b0;
      case (state_q)
         S_IDLE: begin
            rdy = 1'b1;
            if (bus.rd_req) state_d = S_AR;
         end
         S_AR: begin
            ar_vld = 1'b1;
            if (bus.arready) state_d = S_RDATA;
         end
         S_RDATA: begin
            r_rdy = 1'b1;
            if (beat_ok && beat_last) state_d = S_RET;
         end
         S_RET: begin
            ret_vld = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         araddr_q   <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         ret_hold_q <= '0;
         for (int i = 0; i < WORDS; i++) words_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_IDLE) && bus.rd_req) begin
            araddr_q <= {bus.rd_addr[ADDR_W-1:4], 4'b0000};
            cnt_q    <= '0;
            err_q    <= 1'b0;
         end
         if (beat_ok) begin
            words_q[cnt_q] <= bus.rdata;
            // An rlast that disagrees with our own beat count is reported as an error,
            // but it does not steer the FSM.
            err_q <= err_q | (bus.rresp != 2'b00) | (bus.rlast != beat_last);
            if (!beat_last) cnt_q <= cnt_q + CNT_W'(1);
         end
         // ret_data keeps showing the last returned line while the buffer refills.
         if (state_q == S_RET) ret_hold_q <= line;
      end
   end

   assign bus.rd_rdy    = rdy;
   assign bus.ret_valid = ret_vld;
   assign bus.ret_last  = ret_vld;
   assign bus.ret_err   = ret_vld & err_q;
   assign bus.ret_data  = (state_q == S_RET) ? line : ret_hold_q;

   assign bus.arid      = ARID_VAL;
   assign bus.araddr    = araddr_q;
   assign bus.arlen     = 8'(WORDS - 1);
   assign bus.arsize    = 3'b010;
   assign bus.arburst   = 2'b01;
   assign bus.arvalid   = ar_vld;
   assign bus.rready    = r_rdy;
endmodule

// File: tb/tb_icache_refill_bridge.sv
module tb_icache_refill_bridge;
   localparam int ADDR_W = 32;
   localparam int WORDS  = 4;
   localparam int ID_W   = 4;
   localparam int LW     = 32 * WORDS;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   icache_refill_bridge_if #(.ADDR_W(ADDR_W), .WORDS(WORDS), .ID_W(ID_W)) bus();

   icache_refill_bridge #(
      .ADDR_W(ADDR_W), .WORDS(WORDS), .ID_W(ID_W), .ARID_VAL(4'd0)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level reference: the request is outstanding from acceptance
   // until the cycle after the line comes back. The line is made of the first
   // WORDS beats carrying our ID after the AR handshake.
   logic             m_busy, m_arp, m_rph, m_ret, m_err;
   int               m_n;
   logic [31:0]      m_line [WORDS];
   logic [LW-1:0]    m_last;
   logic [ADDR_W-1:0] m_addr;

   function automatic logic [LW-1:0] m_pack();
      logic [LW-1:0] r;
      r = '0;
      for (int i = 0; i < WORDS; i++) r[32*i +: 32] = m_line[i];
      return r;
   endfunction

   task automatic m_reset();
      m_busy = 0; m_arp = 0; m_rph = 0; m_ret = 0; m_err = 0; m_n = 0;
      m_last = '0; m_addr = '0;
      for (int i = 0; i < WORDS; i++) m_line[i] = '0;
   endtask

   initial begin : model
      m_reset();
      forever begin
         @(negedge clk);
         chk("rd_rdy",    bus.rd_rdy,    !m_busy);
         chk("arvalid",   bus.arvalid,   m_arp);
         chk("araddr",    bus.araddr,    m_addr);
         chk("rready",    bus.rready,    m_rph);
         chk("ret_valid", bus.ret_valid, m_ret);
         chk("ret_last",  bus.ret_last,  m_ret);
         chk("ret_err",   bus.ret_err,   m_ret & m_err);
         chk("ret_data",  bus.ret_data,  m_ret ? m_pack() : m_last);
         chk("arid",      bus.arid,      0);
         chk("arlen",     bus.arlen,     WORDS - 1);
         chk("arsize",    bus.arsize,    2);
         chk("arburst",   bus.arburst,   1);
         if (!resetn) m_reset();
         else if (m_ret) begin
            m_last = m_pack(); m_ret = 0; m_busy = 0;
         end else if (!m_busy && bus.rd_req) begin
            m_busy = 1; m_arp = 1; m_n = 0; m_err = 0;
            m_addr = bus.rd_addr & ~32'hF;
         end else if (m_arp && bus.arready) begin
            m_arp = 0; m_rph = 1;
         end else if (m_rph && bus.rvalid && bus.rid == 4'd0) begin
            m_line[m_n] = bus.rdata;
            m_err = m_err | (bus.rresp != 2'b00) | (bus.rlast != (m_n == WORDS - 1));
            m_n++;
            if (m_n == WORDS) begin m_rph = 0; m_ret = 1; end
         end
      end
   end

   // One refill as seen by the ICache and the AXI responder. Indices < 0 or
   // >= WORDS disable the corresponding option.
   task automatic refill(input logic [31:0] addr, input logic [LW-1:0] dline,
                         input int ar_dly, input int gap, input int err_k,
                         input int foreign_k, input int flip_k, input int abort_k,
                         input bit hold, input logic [31:0] next_addr,
                         output logic [LW-1:0] got, output logic got_err,
                         output int t_req, output int t_ret);
      int n;
      got = '0; got_err = 0; t_req = -1; t_ret = -1;
      bus.rd_req = 1; bus.rd_addr = addr;
      n = 0;
      while (!bus.rd_rdy && n < 50) begin step(); n++; end
      chk("req_accept_timeout", bus.rd_rdy, 1);
      t_req = cyc;
      step();
      if (hold) bus.rd_addr = next_addr;
      else bus.rd_req = 0;
      n = 0;
      while (!bus.arvalid && n < 50) begin step(); n++; end
      chk("ar_timeout", bus.arvalid, 1);
      repeat (ar_dly) step();
      bus.arready = 1; step(); bus.arready = 0;
      for (int k = 0; k < WORDS; k++) begin
         if (k == abort_k) begin
            resetn = 0; step(); resetn = 1;
            return;
         end
         repeat (gap) begin bus.rdata = $urandom; step(); end
         if (k == foreign_k) begin
            bus.rvalid = 1; bus.rid = 4'd5; bus.rdata = $urandom;
            bus.rresp = 2'b00; bus.rlast = 0; step();
         end
         bus.rvalid = 1; bus.rid = 4'd0; bus.rdata = dline[32*k +: 32];
         bus.rresp  = (k == err_k) ? 2'b10 : 2'b00;
         bus.rlast  = ((k == WORDS - 1) != (k == flip_k));
         step();
         bus.rvalid = 0; bus.rlast = 0; bus.rresp = 2'b00;
      end
      n = 0;
      while (!bus.ret_valid && n < 50) begin step(); n++; end
      chk("ret_timeout", bus.ret_valid, 1);
      got = bus.ret_data; got_err = bus.ret_err; t_ret = cyc;
   endtask

   logic [LW-1:0] got, d, d2;
   logic          ge;
   int            tq, tr, tq2, tr2;

   initial begin : main
      bus.rd_req = 0; bus.rd_addr = '0; bus.arready = 0; bus.rid = '0;
      bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rvalid = 0;
      resetn = 0;
      repeat (3) @(posedge clk);
      #1 resetn = 1;
      chk("rst_rd_rdy",    bus.rd_rdy,    1);
      chk("rst_arvalid",   bus.arvalid,   0);
      chk("rst_rready",    bus.rready,    0);
      chk("rst_ret_valid", bus.ret_valid, 0);
      chk("rst_ret_data",  bus.ret_data,  0);
      chk("rst_araddr",    bus.araddr,    0);
      step();

      // basic refill with literal expectations
      d = {32'h44, 32'h33, 32'h22, 32'h11};
      refill(32'h1FC0_0024, d, 0, 0, -1, -1, -1, -1, 0, 0, got, ge, tq, tr);
      chk("basic_araddr", bus.araddr, 32'h1FC0_0020);
      chk("basic_arlen",  bus.arlen, 3);
      chk("basic_data",   got, 128'h00000044_00000033_00000022_00000011);
      chk("basic_err",    ge, 0);
      chk("basic_ret_lat", tr - tq, 6);
      step();
      chk("basic_rdy_lat", cyc - tq, 7);
      chk("basic_rdy",     bus.rd_rdy, 1);
      step();

      // backpressure on AR and gapped R beats
      d = {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001};
      refill(32'h0000_1230, d, 5, 1, -1, -1, -1, -1, 0, 0, got, ge, tq, tr);
      chk("bp_data", got, d);
      chk("bp_err",  ge, 0);
      step();

      // error response on beat 2, then a clean line
      d = {32'hE4, 32'hE3, 32'hE2, 32'hE1};
      refill(32'h0000_4000, d, 0, 0, 1, -1, -1, -1, 0, 0, got, ge, tq, tr);
      chk("err_flag", ge, 1);
      chk("err_data", got, d);
      step();
      d = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
      refill(32'h0000_4010, d, 0, 0, -1, -1, -1, -1, 0, 0, got, ge, tq, tr);
      chk("clean_after_err", ge, 0);
      step();

      // foreign-ID beat between beats 1 and 2
      d = {32'hF4, 32'hF3, 32'hF2, 32'hF1};
      refill(32'h0000_5000, d, 0, 0, -1, 1, -1, -1, 0, 0, got, ge, tq, tr);
      chk("foreign_data", got, 128'h000000F4_000000F3_000000F2_000000F1);
      chk("foreign_err",  ge, 0);
      step();

      // reset after two beats
      d = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
      refill(32'h0000_6000, d, 0, 0, -1, -1, -1, 2, 0, 0, got, ge, tq, tr);
      chk("abort_rd_rdy",    bus.rd_rdy,    1);
      chk("abort_arvalid",   bus.arvalid,   0);
      chk("abort_rready",    bus.rready,    0);
      chk("abort_ret_valid", bus.ret_valid, 0);
      d = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
      refill(32'h0000_7000, d, 0, 0, -1, -1, -1, -1, 0, 0, got, ge, tq, tr);
      chk("post_abort_data", got, d);
      chk("post_abort_err",  ge, 0);
      step();

      // back-to-back with rd_req held high
      d  = {32'h104, 32'h103, 32'h102, 32'h101};
      d2 = {32'h204, 32'h203, 32'h202, 32'h201};
      refill(32'h0000_0100, d, 0, 0, -1, -1, -1, -1, 1, 32'h0000_0200, got, ge, tq, tr);
      chk("b2b_data1", got, d);
      refill(32'h0000_0200, d2, 0, 0, -1, -1, -1, -1, 0, 0, got, ge, tq2, tr2);
      chk("b2b_data2",   got, d2);
      chk("b2b_addr2",   bus.araddr, 32'h0000_0200);
      chk("b2b_order",   tq2 > tr, 1);
      step();

      // randomized refills
      for (int it = 0; it < 40; it++) begin
         int ek, fk, lk, ak;
         logic [31:0] a;
         a  = $urandom;
         for (int w = 0; w < WORDS; w++) d[32*w +: 32] = $urandom;
         ek = $urandom_range(0, 7);
         fk = $urandom_range(0, 7);
         lk = $urandom_range(0, 9);
         ak = ($urandom_range(0, 9) == 0) ? $urandom_range(0, WORDS - 1) : -1;
         refill(a, d, $urandom_range(0, 3), $urandom_range(0, 2), ek, fk, lk, ak,
                0, 0, got, ge, tq, tr);
         if (ak < 0) begin
            chk("rand_data", got, d);
            chk("rand_err",  ge, (ek < WORDS) || (lk < WORDS));
         end
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_chk);
      $fatal(1);
   end
endmodule

// File: doc/icache_refill_bridge.md
Name: icache_refill_bridge

Overview:
- Responder end of the ICache refill interface (rd_req/rd_addr/rd_rdy/ret_valid/ret_last/ret_data).
- Converts each accepted line-refill request into one AXI4 INCR read burst of WORDS beats.
- Assembles the beats into a full cache line and returns it to the ICache in a single ret_valid cycle.
- Sits between the ICache and the AXI crossbar/arbiter; read-only, one outstanding request at a time.

Parameters:
- ADDR_W, 32, address width.
- WORDS, 4, 32-bit words per cache line (burst length; arlen = WORDS-1).
- ID_W, 4, AXI ID width.
- ARID_VAL, 0, fixed ID driven on arid and expected on rid.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- rd_req  in  1  ICache line refill request; held until accepted.
- rd_addr  in  ADDR_W  physical line address; low 4 bits ignored.
- rd_rdy  out  1  bridge can accept a request this cycle.
- ret_valid  out  1  returned line valid, one-cycle pulse.
- ret_last  out  1  equals ret_valid (whole line in one transfer).
- ret_data  out  32*WORDS  line; word i at bits [32i+31:32i].
- ret_err  out  1  valid with ret_valid; 1 if any beat of the line had rresp != OKAY.
- arid  out  ID_W  = ARID_VAL.
- araddr  out  ADDR_W  line-aligned address.
- arlen  out  8  = WORDS-1.
- arsize  out  3  = 3'b010.
- arburst  out  2  = 2'b01 (INCR).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  ID_W  R ID.
- rdata  in  32  R data.
- rresp  in  2  R response.
- rlast  in  1  R last.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset: resetn is synchronous and active-low; clock is clk.
  - Reset value of all outputs: state IDLE, rd_rdy=1, arvalid=0, rready=0, ret_valid=0, ret_last=0, ret_err=0, ret_data=0, araddr=0, beat counter=0.
  - Reset mid-burst aborts to IDLE and clears buffered words and error; the AXI side is reset by the same resetn.
- FSM:
  - IDLE: rd_rdy=1. On rd_req, latch araddr={rd_addr[ADDR_W-1:4],4'b0} and clear the counter and error; go to AR.
  - AR: arvalid=1, araddr stable. On arready go to RDATA. arvalid drops the cycle after the handshake.
  - RDATA: rready=1.
    - Each rvalid beat with rid==ARID_VAL writes rdata into word[cnt], ORs (rresp!=0) into the error flag, and increments cnt.
    - Beats with rid!=ARID_VAL are consumed and discarded.
    - Go to RET when the beat with cnt==WORDS-1 is accepted.
    - rlast is not used for control. A mismatch (rlast on a beat other than cnt==WORDS-1, or missing on that beat) also sets the error flag.
  - RET: ret_valid=ret_last=1 for exactly one cycle; ret_data and ret_err are driven from the buffer. Next state IDLE.
- rd_rdy is 0 in AR, RDATA and RET. A request arriving then is not accepted; the requester holds rd_req.
- ret_data holds its last value after RET until the next RET.
- Latency:
  - rd_req accepted at cycle T; arvalid=1 from T+1.
  - With arready=1 at T+1 and back-to-back beats at T+2..T+5, ret_valid is at T+6 and rd_rdy=1 again at T+7.
- cnt is log2(WORDS) bits wide and never wraps within a line; it is cleared on acceptance.

Test Plan:
- Basic refill: rd_req with rd_addr=0x1FC0_0024, arready=1, 4 beats 0x11,0x22,0x33,0x44 with rlast on beat 4 -> araddr=0x1FC0_0020, arlen=3, arsize=2, arburst=1; ret_data=0x00000044_00000033_00000022_00000011; ret_valid one cycle at T+6; ret_err=0.
- Backpressure: arready held low 5 cycles, rvalid gapped (beats every other cycle) -> araddr and arvalid stable until handshake; ret_valid exactly once after the 4th beat; rd_rdy=0 throughout.
- Error: beat 2 with rresp=2'b10 -> ret_err=1 with ret_valid. The next clean refill returns ret_err=0.
- Foreign ID: a beat with rid!=ARID_VAL inserted between beats 1 and 2 -> it is discarded; ret_data contains only the four matching beats in order.
- Reset mid-burst: resetn low after 2 beats -> next cycle rd_rdy=1, arvalid=0, rready=0, ret_valid=0. A new request completes normally with fresh data.
- Back-to-back: rd_req held high across two lines (0x100, 0x200) -> the second AR issues only after the first RET; two ret_valid pulses with correct data each.
